char_console_writer: RTL and testbench
======================================

// Module: char_console_writer
// PURPOSE
//  Text-console front end for the 80x30 character/colour memory scanned by the VGA character generator.
//  Accepts an ASCII byte stream (valid/ready) and writes glyph+colour words at a tracked cursor.
//  Handles CR/LF/BS/FF, wraps at column 79 and scrolls at row 29 by copying the memory through its data port.
//  Sits between a stream source (UART RX or CPU MMIO) and the memory's data-side port (clk_data domain).
// PARAMETERS
//  COLS   80  visible columns; cursor_x range 0..COLS-1
//  ROWS   30  visible rows; cursor_y range 0..ROWS-1
//  COL_W  7   column field width of the address
//  ROW_W  5   row field width of the address; COL_W+ROW_W = 12
// PORTS
//  clk         in   1   single clock (memory data-side clock)
//  rst_n       in   1   reset, asynchronous, active-low
//  ch_valid    in   1   ch_data valid
//  ch_data     in   8   ASCII byte
//  ch_ready    out  1   block accepts ch_data this cycle
//  fg_color    in   12  foreground colour, sampled on accept
//  bg_color    in   12  background colour, sampled on accept
//  char_we     out  1   memory write enable
//  char_addr   out  12  memory address {row[ROW_W-1:0], col[COL_W-1:0]}
//  char_value  out  32  write word: [31:20]=bg, [19:8]=fg, [7]=0, [6:0]=char
//  char_rdata  in   32  memory read data, valid 1 cycle after char_addr presented
//  cursor_x    out  7   current column
//  cursor_y    out  5   current row
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cursor=(0,0), latched char/colours=0; char_we=0, char_addr=0,
//   char_value=0, busy=0, ch_ready=1 after release. Memory contents untouched. Reset mid-scroll/clear aborts at once.
//  char_we/char_addr/char_value are combinational decodes of state+counters; char_we=0 outside PUT/SCROLL_WR/CLR_*.
//  Handshake: ch_ready = (state==IDLE); transfer on ch_valid&&ch_ready; byte and colours latched at transfer.
//   ch_valid held with ch_ready=0 is not consumed; data may change only after transfer.
//  Byte decode at transfer (IDLE ->):
//   0x20..0x7E  -> PUT
//   0x0D CR     -> col=0; stay IDLE
//   0x0A LF     -> col=0; row<ROWS-1: row+1, IDLE; row==ROWS-1: SCROLL_RD
//   0x08 BS     -> col>0: col-1 then PUT with char 0x20 at new col, cursor not advanced; col==0: no-op
//   0x0C FF     -> CLR_ALL, cursor=(0,0)
//   other       -> consumed, ignored
//  PUT (1 cycle): we=1, addr={row,col}, value={bg,fg,1'b0,ch[6:0]}. Then advance:
//   col<COLS-1: col+1, IDLE. col==COLS-1 & row<ROWS-1: (0,row+1), IDLE. col==COLS-1 & row==ROWS-1: col=0, SCROLL_RD.
//  Printable write latency: word appears on port the cycle after transfer; max rate 1 char / 2 cycles.
//  SCROLL: counters r=0..ROWS-2, c=0..COLS-1.
//   SCROLL_RD: we=0, addr={r+1,c}. SCROLL_WR: we=1, addr={r,c}, value=char_rdata (unaltered, colours kept).
//   Advance c, wrap c to 0 and r+1; after (ROWS-2,COLS-1) -> CLR_ROW. 2 cycles per cell.
//  CLR_ROW: write {bg,fg,8'h20} to row ROWS-1, cols 0..COLS-1, 1 cell/cycle -> IDLE; cursor=(0,ROWS-1).
//   Total scroll = (ROWS-1)*COLS*2 + COLS = 4720 cycles for 80x30.
//  CLR_ALL: write {bg,fg,8'h20} to every cell, row-major from (0,0), 1 cell/cycle, 2400 cycles -> IDLE.
//  Addresses with col>=COLS or row>=ROWS are never driven. Colours used by CLR_* / BS are those latched at transfer.
// TESTING
//  Reset, send 'A'(0x41) fg=0xFFF bg=0x00F -> one write addr 0x000 value 0x00FFFF41; cursor (1,0); ch_ready low 1 cycle.
//  Cursor at (79,5), send 'Z' -> write addr {5,79}=0x2CF; cursor (0,6); no scroll.
//  Fill row 1 col 0 with 'Q', cursor (3,29), send LF -> busy 4720 cycles; cell (0,0) reads 'Q' word;
//   row 29 all 0x20 in latched colours; cursor (0,29).
//  Cursor (4,2), send BS -> write 0x20 at addr 0x103; cursor (3,2). At col 0 BS -> no write, cursor unchanged.
//  Send FF -> 2400 writes addr 0x000..{29,79} of 0x20 word; cursor (0,0); ch_ready held low throughout.
//  Pull rst_n low mid-scroll -> char_we=0 same cycle; after release cursor (0,0), IDLE, next byte written at 0x000.

Source files
------------

// File: rtl/char_console_writer.sv
// char_console_writer: ASCII stream to 80x30 character/colour memory writer.
// Tracks a text cursor, handles CR/LF/BS/FF, wraps at the last column and
// scrolls at the last row by copying memory through its data port.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ch_valid/ch_data/ch_ready  byte stream handshake (transfer on valid&&ready)
//   fg_color, bg_color     colours sampled on transfer
//   char_we/char_addr/char_value  memory write port ({row,col} address)
//   char_rdata             memory read data, one cycle after char_addr
//   cursor_x, cursor_y     current cursor position
//   busy                   high while a write, scroll or clear is in progress
module char_console_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ch_valid,
  input  logic [7:0]             ch_data,
  output logic                   ch_ready,
  input  logic [11:0]            fg_color,
  input  logic [11:0]            bg_color,
  output logic                   char_we,
  output logic [ROW_W+COL_W-1:0] char_addr,
  output logic [31:0]            char_value,
  input  logic [31:0]            char_rdata,
  output logic [COL_W-1:0]       cursor_x,
  output logic [ROW_W-1:0]       cursor_y,
  output logic                   busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(ROWS - 2);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PUT       = 3'd1;
  localparam logic [2:0] S_SCROLL_RD = 3'd2;
  localparam logic [2:0] S_SCROLL_WR = 3'd3;
  localparam logic [2:0] S_CLR_ROW   = 3'd4;
  localparam logic [2:0] S_CLR_ALL   = 3'd5;

  logic [2:0]       state, state_n;
  logic [COL_W-1:0] cx, cx_n, cc, cc_n;
  logic [ROW_W-1:0] cy, cy_n, rc, rc_n;
  logic [6:0]       ch_q, ch_n;
  logic [11:0]      fg_q, fg_n, bg_q, bg_n;
  logic             no_adv, no_adv_n;

  assign ch_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign cursor_x = cx;
  assign cursor_y = cy;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cx     <= '0;
      cy     <= '0;
      cc     <= '0;
      rc     <= '0;
      ch_q   <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
      no_adv <= 1'b0;
    end else begin
      state  <= state_n;
      cx     <= cx_n;
      cy     <= cy_n;
      cc     <= cc_n;
      rc     <= rc_n;
      ch_q   <= ch_n;
      fg_q   <= fg_n;
      bg_q   <= bg_n;
      no_adv <= no_adv_n;
    end
  end

  // Next-state, cursor/counter update and memory port decode
  always_comb begin
    state_n    = state;
    cx_n       = cx;
    cy_n       = cy;
    cc_n       = cc;
    rc_n       = rc;
    ch_n       = ch_q;
    fg_n       = fg_q;
    bg_n       = bg_q;
    no_adv_n   = no_adv;
    char_we    = 1'b0;
    char_addr  = '0;
    char_value = '0;

    case (state)
      S_IDLE: begin
        if (ch_valid) begin
          fg_n     = fg_color;
          bg_n     = bg_color;
          ch_n     = ch_data[6:0];
          no_adv_n = 1'b0;
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            state_n = S_PUT;
          end else begin
            case (ch_data)
              8'h0D: cx_n = '0;
              8'h0A: begin
                cx_n = '0;
                if (cy == ROW_LAST) begin
                  rc_n    = '0;
                  cc_n    = '0;
                  state_n = S_SCROLL_RD;
                end else begin
                  cy_n = cy + ROW_W'(1);
                end
              end
              8'h08: begin
                // Backspace erases the previous cell without advancing after the write
                if (cx != '0) begin
                  cx_n     = cx - COL_W'(1);
                  ch_n     = 7'h20;
                  no_adv_n = 1'b1;
                  state_n  = S_PUT;
                end
              end
              8'h0C: begin
                cx_n    = '0;
                cy_n    = '0;
                rc_n    = '0;
                cc_n    = '0;
                state_n = S_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      S_PUT: begin
        char_we    = 1'b1;
        char_addr  = {cy, cx};
        char_value = {bg_q, fg_q, 1'b0, ch_q};
        state_n    = S_IDLE;
        if (!no_adv) begin
          if (cx != COL_LAST) begin
            cx_n = cx + COL_W'(1);
          end else begin
            cx_n = '0;
            if (cy != ROW_LAST) begin
              cy_n = cy + ROW_W'(1);
            end else begin
              rc_n    = '0;
              cc_n    = '0;
              state_n = S_SCROLL_RD;
            end
          end
        end
      end

      // Read the cell one row below; its data is written back on the next cycle
      S_SCROLL_RD: begin
        char_addr = {rc + ROW_W'(1), cc};
        state_n   = S_SCROLL_WR;
      end

      S_SCROLL_WR: begin
        char_we    = 1'b1;
        char_addr  = {rc, cc};
        char_value = char_rdata;
        state_n    = S_SCROLL_RD;
        if (cc == COL_LAST) begin
          cc_n = '0;
          if (rc == ROW_PEN) state_n = S_CLR_ROW;
          else               rc_n    = rc + ROW_W'(1);
        end else begin
          cc_n = cc + COL_W'(1);
        end
      end

      S_CLR_ROW: begin
        char_we    = 1'b1;
        char_addr  = {ROW_LAST, cc};
        char_value = {bg_q, fg_q, 8'h20};
        if (cc == COL_LAST) begin
          cc_n    = '0;
          cx_n    = '0;
          cy_n    = ROW_LAST;
          state_n = S_IDLE;
        end else begin
          cc_n = cc + COL_W'(1);
        end
      end

      S_CLR_ALL: begin
        char_we    = 1'b1;
        char_addr  = {rc, cc};
        char_value = {bg_q, fg_q, 8'h20};
        if (cc == COL_LAST) begin
          cc_n = '0;
          if (rc == ROW_LAST) state_n = S_IDLE;
          else                rc_n    = rc + ROW_W'(1);
        end else begin
          cc_n = cc + COL_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_char_console_writer.sv
// Self-checking bench for char_console_writer: a bench-side memory captures
// the writes, and a screen/cursor model predicts the console contents.
module tb_char_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic        char_we;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [31:0] char_rdata;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:4095];
  logic [43:0] wq [$];

  logic [31:0] scr [0:ROWS*COLS-1];
  int mx, my;

  always #5 clk = ~clk;

  char_console_writer dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .fg_color(fg_color), .bg_color(bg_color), .char_we(char_we), .char_addr(char_addr),
    .char_value(char_value), .char_rdata(char_rdata), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .busy(busy)
  );

  // Memory: synchronous write, one-cycle read latency, plus write log
  always @(posedge clk) begin
    char_rdata <= mem[char_addr];
    if (char_we === 1'b1) begin
      mem[char_addr] <= char_value;
      wq.push_back({char_addr, char_value});
      checks++;
      if (char_addr[6:0] >= 7'(COLS) || char_addr[11:7] >= 5'(ROWS)) begin
        failures++;
        $display("FAIL addr_range got=%h", char_addr);
      end
    end
  end

  function automatic logic [11:0] addr_of(input int i);
    return {5'(i / COLS), 7'(i % COLS)};
  endfunction

  task automatic model_scroll(input logic [11:0] f, input logic [11:0] g);
    for (int i = 0; i < (ROWS - 1) * COLS; i++) scr[i] = scr[i + COLS];
    for (int c = 0; c < COLS; c++) scr[(ROWS - 1) * COLS + c] = {g, f, 8'h20};
  endtask

  task automatic model_apply(input logic [7:0] b, input logic [11:0] f, input logic [11:0] g);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[my * COLS + mx] = {g, f, 1'b0, b[6:0]};
      mx++;
      if (mx == COLS) begin
        mx = 0;
        if (my == ROWS - 1) model_scroll(f, g);
        else my++;
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      mx = 0;
      if (my == ROWS - 1) model_scroll(f, g);
      else my++;
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my * COLS + mx] = {g, f, 8'h20};
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < ROWS * COLS; i++) scr[i] = {g, f, 8'h20};
      mx = 0;
      my = 0;
    end
  endtask

  // Transfers one byte (called at a negedge), returns the number of busy cycles
  task automatic send(input logic [7:0] b, input logic [11:0] f, input logic [11:0] g,
                      output int bcyc);
    int n;
    n = 0;
    while (ch_ready !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
    if (ch_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_timeout got=%b want=1", ch_ready);
    end
    ch_valid = 1'b1; ch_data = b; fg_color = f; bg_color = g;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data = 8'($urandom); fg_color = 12'($urandom); bg_color = 12'($urandom);
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 6000) begin bcyc++; @(negedge clk); end
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL busy_timeout got=%b want=0", busy);
    end
    model_apply(b, f, g);
  endtask

  task automatic goto_xy(input int x, input int y);
    int d;
    send(8'h0C, 12'h000, 12'h000, d);
    repeat (y) send(8'h0A, 12'($urandom), 12'($urandom), d);
    repeat (x) send(8'h2E, 12'($urandom), 12'($urandom), d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ch_valid = 1'b0; ch_data = 8'h00; fg_color = '0; bg_color = '0;
    mx = 0; my = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < ROWS * COLS; i++) scr[i] = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (char_we !== 1'b0 || char_addr !== 12'h000 || char_value !== 32'h0) begin
      failures++;
      $display("FAIL reset_port got=%b/%h/%h want=0/000/00000000", char_we, char_addr, char_value);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ch_ready !== 1'b1 || busy !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      failures++;
      $display("FAIL reset_state got=rdy%b busy%b (%0d,%0d) want=rdy1 busy0 (0,0)",
               ch_ready, busy, cursor_x, cursor_y);
    end
  endtask

  task automatic test_put_a;
    int bc;
    wq.delete();
    send(8'h41, 12'hFFF, 12'h00F, bc);
    checks++;
    if (wq.size() != 1 || wq[0] !== {12'h000, 32'h00FFFF41}) begin
      failures++;
      $display("FAIL put_a n=%0d got=%h want=00000FFFF41", wq.size(), wq.size() ? wq[0] : 44'h0);
    end
    checks++;
    if (cursor_x !== 7'd1 || cursor_y !== 5'd0 || bc != 1) begin
      failures++;
      $display("FAIL put_a_cursor got=(%0d,%0d) busy=%0d want=(1,0) busy=1", cursor_x, cursor_y, bc);
    end
  endtask

  task automatic test_wrap;
    int bc;
    goto_xy(79, 5);
    wq.delete();
    send(8'h5A, 12'hABC, 12'h321, bc);
    checks++;
    if (wq.size() != 1 || wq[0] !== {12'h2CF, 12'h321, 12'hABC, 8'h5A}) begin
      failures++;
      $display("FAIL wrap_write n=%0d got=%h want=2CF321ABC5A", wq.size(), wq.size() ? wq[0] : 44'h0);
    end
    checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd6 || bc != 1) begin
      failures++;
      $display("FAIL wrap_cursor got=(%0d,%0d) busy=%0d want=(0,6) busy=1", cursor_x, cursor_y, bc);
    end
  endtask

  task automatic test_bs;
    int bc;
    goto_xy(4, 2);
    wq.delete();
    send(8'h08, 12'h0F0, 12'h00A, bc);
    checks++;
    if (wq.size() != 1 || wq[0] !== {12'h103, 12'h00A, 12'h0F0, 8'h20}) begin
      failures++;
      $display("FAIL bs_write n=%0d got=%h want=10300A0F020", wq.size(), wq.size() ? wq[0] : 44'h0);
    end
    checks++;
    if (cursor_x !== 7'd3 || cursor_y !== 5'd2) begin
      failures++;
      $display("FAIL bs_cursor got=(%0d,%0d) want=(3,2)", cursor_x, cursor_y);
    end
    send(8'h0D, 12'h0, 12'h0, bc);
    wq.delete();
    send(8'h08, 12'h111, 12'h222, bc);
    checks++;
    if (wq.size() != 0 || cursor_x !== 7'd0 || cursor_y !== 5'd2) begin
      failures++;
      $display("FAIL bs_col0 writes=%0d got=(%0d,%0d) want=0 writes (0,2)", wq.size(), cursor_x, cursor_y);
    end
  endtask

  task automatic test_scroll;
    int bc, bad;
    int d;
    send(8'h0C, 12'h000, 12'h000, d);
    send(8'h0A, 12'h000, 12'h000, d);
    send(8'h51, 12'h5A5, 12'h0C3, d);
    repeat (28) send(8'h0A, 12'($urandom), 12'($urandom), d);
    repeat (3) send(8'h78, 12'($urandom), 12'($urandom), d);
    send(8'h0A, 12'h123, 12'h456, bc);
    checks++;
    if (bc != 4720) begin
      failures++;
      $display("FAIL scroll_cycles got=%0d want=4720", bc);
    end
    checks++;
    if (mem[0] !== {12'h0C3, 12'h5A5, 8'h51}) begin
      failures++;
      $display("FAIL scroll_copy got=%h want=0C35A551", mem[0]);
    end
    bad = 0;
    for (int c = 0; c < COLS; c++)
      if (mem[{5'd29, 7'(c)}] !== {12'h456, 12'h123, 8'h20}) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL scroll_clr_row bad_cells=%0d want=0", bad);
    end
    checks++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
      failures++;
      $display("FAIL scroll_cursor got=(%0d,%0d) want=(0,29)", cursor_x, cursor_y);
    end
    bad = 0;
    for (int i = 0; i < ROWS * COLS; i++) if (mem[addr_of(i)] !== scr[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL scroll_screen bad_cells=%0d want=0", bad);
    end
  endtask

  // FF followed by a byte held valid during the whole clear
  task automatic test_clear_backpressure;
    int n, rdy_bad, bad, bc;
    wq.delete();
    ch_valid = 1'b1; ch_data = 8'h0C; fg_color = 12'h7E1; bg_color = 12'h1E7;
    @(negedge clk);
    ch_data = 8'h4B; fg_color = 12'h333; bg_color = 12'h444;
    n = 0; rdy_bad = 0;
    while (busy === 1'b1 && n < 6000) begin
      n++;
      if (ch_ready !== 1'b0) rdy_bad++;
      @(negedge clk);
    end
    @(negedge clk);
    ch_valid = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin bc++; @(negedge clk); end
    model_apply(8'h0C, 12'h7E1, 12'h1E7);
    model_apply(8'h4B, 12'h333, 12'h444);
    checks++;
    if (n != 2400 || rdy_bad != 0) begin
      failures++;
      $display("FAIL clr_cycles got=%0d rdy_high=%0d want=2400 rdy_high=0", n, rdy_bad);
    end
    bad = 0;
    if (wq.size() != 2401) bad = 9999;
    else for (int i = 0; i < ROWS * COLS; i++)
      if (wq[i] !== {addr_of(i), 12'h1E7, 12'h7E1, 8'h20}) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clr_sequence writes=%0d bad=%0d want=2401 bad=0", wq.size(), bad);
    end
    checks++;
    if (wq.size() != 2401 || wq[wq.size() - 1] !== {12'h000, 12'h444, 12'h333, 8'h4B}) begin
      failures++;
      $display("FAIL held_byte writes=%0d want=2401 with K at 000", wq.size());
    end
    checks++;
    if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
      failures++;
      $display("FAIL clr_cursor got=(%0d,%0d) want=(1,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_random;
    int bc, bad, r;
    logic [7:0] b;
    logic [11:0] f, g;
    logic [43:0] ew;
    bit has_w, may_scroll;
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      b = 8'(8'h20 + $urandom_range(0, 94));
      else if (r < 86) b = 8'h0A;
      else if (r < 90) b = 8'h0D;
      else if (r < 96) b = 8'h08;
      else begin
        b = 8'($urandom);
        if (b == 8'h0C) b = 8'h00;
      end
      f = 12'($urandom); g = 12'($urandom);
      has_w = 1'b0; ew = '0;
      may_scroll = (b == 8'h0A && my == ROWS - 1);
      if (b >= 8'h20 && b <= 8'h7E) begin
        has_w = 1'b1; ew = {5'(my), 7'(mx), g, f, 1'b0, b[6:0]};
      end else if (b == 8'h08 && mx > 0) begin
        has_w = 1'b1; ew = {5'(my), 7'(mx - 1), g, f, 8'h20};
      end
      wq.delete();
      send(b, f, g, bc);
      if (has_w) begin
        checks++;
        if (wq.size() < 1 || wq[0] !== ew) begin
          failures++;
          $display("FAIL rand_write it=%0d byte=%h got=%h want=%h", it, b, wq.size() ? wq[0] : 44'h0, ew);
        end
      end else if (!may_scroll) begin
        checks++;
        if (wq.size() != 0) begin
          failures++;
          $display("FAIL rand_nowrite it=%0d byte=%h writes=%0d want=0", it, b, wq.size());
        end
      end
      checks++;
      if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin
        failures++;
        $display("FAIL rand_cursor it=%0d byte=%h got=(%0d,%0d) want=(%0d,%0d)",
                 it, b, cursor_x, cursor_y, mx, my);
      end
    end
    bad = 0;
    for (int i = 0; i < ROWS * COLS; i++) if (mem[addr_of(i)] !== scr[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_screen bad_cells=%0d want=0", bad);
    end
  endtask

  task automatic test_reset_mid_scroll;
    int n, bc;
    goto_xy(0, 29);
    ch_valid = 1'b1; ch_data = 8'h0A; fg_color = 12'h0; bg_color = 12'h0;
    @(negedge clk);
    ch_valid = 1'b0;
    repeat (300) @(negedge clk);
    n = 0;
    while (char_we !== 1'b1 && n < 10) begin n++; @(negedge clk); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (char_we !== 1'b0 || busy !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      failures++;
      $display("FAIL rst_abort got=we%b busy%b (%0d,%0d) want=we0 busy0 (0,0)",
               char_we, busy, cursor_x, cursor_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mx = 0; my = 0;
    @(negedge clk);
    wq.delete();
    send(8'h42, 12'h0AB, 12'hCD0, bc);
    checks++;
    if (wq.size() != 1 || wq[0] !== {12'h000, 12'hCD0, 12'h0AB, 8'h42}) begin
      failures++;
      $display("FAIL rst_next_write n=%0d got=%h want=000CD00AB42", wq.size(), wq.size() ? wq[0] : 44'h0);
    end
    checks++;
    if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin
      failures++;
      $display("FAIL rst_next_cursor got=(%0d,%0d) want=(1,0)", cursor_x, cursor_y);
    end
  endtask

  initial begin
    test_reset();
    test_put_a();
    test_wrap();
    test_bs();
    test_scroll();
    test_clear_backpressure();
    test_random();
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
